// File: rtl/mem_arbiter_if.sv
// Request/response bundle between fetch, load/store and the shared memory.
// The arbiter takes the slave view; the requesters/memory side take master.
interface mem_arbiter_if;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_ready;
  logic        o_if_valid;
  logic [31:0] o_if_rdata;
  logic        i_dm_req;
  logic [31:0] i_dm_addr;
  logic        i_dm_wen;
  logic [31:0] i_dm_wdata;
  logic [3:0]  i_dm_mask;
  logic        o_dm_ready;
  logic        o_dm_valid;
  logic [31:0] o_dm_rdata;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready;
  logic        i_mem_valid;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_ready, o_if_valid, o_if_rdata,
    input  i_dm_req, i_dm_addr, i_dm_wen,
    input  i_dm_wdata, i_dm_mask,
    output o_dm_ready, o_dm_valid, o_dm_rdata,
    output o_mem_req, o_mem_addr, o_mem_wen,
    output o_mem_wdata, o_mem_mask,
    input  i_mem_ready, i_mem_valid, i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_ready, o_if_valid, o_if_rdata,
    output i_dm_req, i_dm_addr, i_dm_wen,
    output i_dm_wdata, i_dm_mask,
    input  o_dm_ready, o_dm_valid, o_dm_rdata,
    input  o_mem_req, o_mem_addr, o_mem_wen,
    input  o_mem_wdata, o_mem_mask,
    output i_mem_ready, i_mem_valid, i_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-ported memory, one transaction in flight.
// Data wins ties until fetch has been passed over STARVE_LIMIT times.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic           i_clk,
  input logic           i_rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t      state;
  logic        owner;
  logic [3:0]  cnt;
  logic        mem_req_q;
  logic [31:0] t_addr;
  logic        t_wen;
  logic [31:0] t_wdata;
  logic [3:0]  t_mask;

  logic idle;
  logic starve;
  logic grant_d;
  logic grant_f;
  logic fin;

  assign idle    = (state == S_IDLE);
  assign starve  = (cnt >= 4'(STARVE_LIMIT));
  assign grant_d = idle && bus.i_dm_req
                && !(bus.i_if_req && starve);
  assign grant_f = idle && bus.i_if_req && !grant_d;
  assign fin     = (state == S_WAIT) && bus.i_mem_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      cnt       <= '0;
      mem_req_q <= 1'b0;
      t_addr    <= '0;
      t_wen     <= 1'b0;
      t_wdata   <= '0;
      t_mask    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            grant_d: begin
              owner     <= 1'b1;
              t_addr    <= {bus.i_dm_addr[31:2], 2'b00};
              t_wen     <= bus.i_dm_wen;
              t_wdata   <= bus.i_dm_wdata;
              t_mask    <= bus.i_dm_mask;
              mem_req_q <= 1'b1;
              state     <= S_ISSUE;
              // Only a data win over a waiting fetch counts.
              if (!bus.i_if_req)
                cnt <= '0;
              else if (cnt != 4'hf)
                cnt <= cnt + 4'd1;
            end
            grant_f: begin
              owner     <= 1'b0;
              t_addr    <= {bus.i_if_addr[31:2], 2'b00};
              t_wen     <= 1'b0;
              t_wdata   <= '0;
              t_mask    <= 4'b1111;
              mem_req_q <= 1'b1;
              state     <= S_ISSUE;
              cnt       <= '0;
            end
            default: ;
          endcase
        end
        S_ISSUE: begin
          if (bus.i_mem_ready) begin
            mem_req_q <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.i_mem_valid)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_if_ready  = grant_f;
  assign bus.o_dm_ready  = grant_d;
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_addr  = t_addr;
  assign bus.o_mem_wen   = t_wen;
  assign bus.o_mem_wdata = t_wdata;
  assign bus.o_mem_mask  = t_mask;
  assign bus.o_if_valid  = fin && !owner;
  assign bus.o_dm_valid  = fin && owner;
  assign bus.o_if_rdata  = (fin && !owner) ? bus.i_mem_rdata : '0;
  assign bus.o_dm_rdata  = (fin && owner)  ? bus.i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, starvation order,
// memory stalls, reset mid-transaction and a stray memory response.
module tb_mem_arbiter;

  logic i_clk = 1'b0;
  logic i_rst;

  always #5 i_clk = ~i_clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk_fields(input logic [31:0] addr,
                            input logic        wen,
                            input logic [31:0] wd,
                            input logic [3:0]  mask);
    chk("mem_addr",  bus.o_mem_addr,  addr);
    chk("mem_wen",   32'(bus.o_mem_wen), 32'(wen));
    chk("mem_wdata", bus.o_mem_wdata, wd);
    chk("mem_mask",  32'(bus.o_mem_mask), 32'(mask));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rdy"},
        {30'b0, bus.o_if_ready, bus.o_dm_ready}, 32'd0);
    chk({tag, "_vld"},
        {30'b0, bus.o_if_valid, bus.o_dm_valid}, 32'd0);
  endtask

  // Called one cycle after accept: drives the memory side through
  // rdly stall cycles, the accept, vdly wait cycles and the response.
  task automatic mem_cycle(input int          rdly,
                           input int          vdly,
                           input logic        dm,
                           input logic [31:0] addr,
                           input logic        wen,
                           input logic [31:0] wd,
                           input logic [3:0]  mask,
                           input logic [31:0] rd);
    for (int i = 0; i < rdly; i++) begin
      bus.i_mem_ready = 1'b0;
      settle();
      chk("stall_req", 32'(bus.o_mem_req), 32'd1);
      chk_fields(addr, wen, wd, mask);
      chk_quiet("stall");
      step();
    end
    bus.i_mem_ready = 1'b1;
    settle();
    chk("issue_req", 32'(bus.o_mem_req), 32'd1);
    chk_fields(addr, wen, wd, mask);
    chk_quiet("issue");
    step();
    bus.i_mem_ready = 1'b0;
    for (int i = 0; i < vdly; i++) begin
      settle();
      chk("wait_req", 32'(bus.o_mem_req), 32'd0);
      chk_quiet("wait");
      step();
    end
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = rd;
    settle();
    chk("if_valid", 32'(bus.o_if_valid), 32'(!dm));
    chk("dm_valid", 32'(bus.o_dm_valid), 32'(dm));
    chk("rdata", dm ? bus.o_dm_rdata : bus.o_if_rdata, rd);
    chk("resp_rdy", {30'b0, bus.o_if_ready, bus.o_dm_ready}, 32'd0);
    step();
    bus.i_mem_valid = 1'b0;
    bus.i_mem_rdata = '0;
    settle();
    chk("post_vld", {30'b0, bus.o_if_valid, bus.o_dm_valid}, 32'd0);
  endtask

  logic [9:0] fseq;

  initial begin
    i_rst           = 1'b1;
    bus.i_if_req    = 1'b0;
    bus.i_if_addr   = '0;
    bus.i_dm_req    = 1'b0;
    bus.i_dm_addr   = '0;
    bus.i_dm_wen    = 1'b0;
    bus.i_dm_wdata  = '0;
    bus.i_dm_mask   = '0;
    bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b0;
    bus.i_mem_rdata = '0;
    step();
    step();
    settle();
    chk("rst_req", 32'(bus.o_mem_req), 32'd0);
    chk_fields(32'd0, 1'b0, 32'd0, 4'd0);
    chk_quiet("rst");
    i_rst = 1'b0;
    step();

    // single fetch, unaligned address
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0106;
    settle();
    chk("f_if_ready", 32'(bus.o_if_ready), 32'd1);
    chk("f_dm_ready", 32'(bus.o_dm_ready), 32'd0);
    step();
    bus.i_if_req = 1'b0;
    mem_cycle(0, 0, 1'b0, 32'h0000_0104, 1'b0, 32'd0, 4'hf,
              32'h0050_0093);

    // store pass-through
    bus.i_dm_req   = 1'b1;
    bus.i_dm_wen   = 1'b1;
    bus.i_dm_addr  = 32'h0000_2003;
    bus.i_dm_wdata = 32'hAB00_0000;
    bus.i_dm_mask  = 4'b1000;
    settle();
    chk("s_dm_ready", 32'(bus.o_dm_ready), 32'd1);
    chk("s_if_ready", 32'(bus.o_if_ready), 32'd0);
    step();
    bus.i_dm_req = 1'b0;
    mem_cycle(0, 0, 1'b1, 32'h0000_2000, 1'b1, 32'hAB00_0000,
              4'b1000, 32'h0000_0000);

    // both held: D,D,D,D,F,D,D,D,D,F
    fseq           = 10'b10000_10000;
    bus.i_if_req   = 1'b1;
    bus.i_if_addr  = 32'h0000_0200;
    bus.i_dm_req   = 1'b1;
    bus.i_dm_wen   = 1'b0;
    bus.i_dm_addr  = 32'h0000_0301;
    bus.i_dm_wdata = 32'h1234_5678;
    bus.i_dm_mask  = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk($sformatf("grant%0d", k),
          {30'b0, bus.o_if_ready, bus.o_dm_ready},
          fseq[k] ? 32'd2 : 32'd1);
      step();
      if (fseq[k])
        mem_cycle(0, 0, 1'b0, 32'h0000_0200, 1'b0, 32'd0,
                  4'hf, 32'hF000_0000 + k);
      else
        mem_cycle(0, 0, 1'b1, 32'h0000_0300, 1'b0,
                  32'h1234_5678, 4'hf, 32'hD000_0000 + k);
    end
    bus.i_if_req = 1'b0;
    bus.i_dm_req = 1'b0;
    step();

    // memory stall: 5 cycles not ready, 3 cycles to respond
    bus.i_dm_req   = 1'b1;
    bus.i_dm_wen   = 1'b0;
    bus.i_dm_addr  = 32'h0000_4444;
    bus.i_dm_wdata = 32'h0;
    bus.i_dm_mask  = 4'b0011;
    settle();
    chk("st_dm_ready", 32'(bus.o_dm_ready), 32'd1);
    step();
    bus.i_dm_req = 1'b0;
    mem_cycle(5, 3, 1'b1, 32'h0000_4444, 1'b0, 32'h0, 4'b0011,
              32'hCAFE_F00D);

    // reset while in WAIT
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h0000_0800;
    settle();
    chk("r_if_ready", 32'(bus.o_if_ready), 32'd1);
    step();
    bus.i_if_req    = 1'b0;
    bus.i_mem_ready = 1'b1;
    step();
    bus.i_mem_ready = 1'b0;
    i_rst           = 1'b1;
    step();
    settle();
    chk("r_mem_req", 32'(bus.o_mem_req), 32'd0);
    chk_fields(32'd0, 1'b0, 32'd0, 4'd0);
    chk_quiet("r_in");
    i_rst           = 1'b0;
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'hDEAD_BEEF;
    bus.i_if_req    = 1'b1;
    bus.i_if_addr   = 32'h0000_0042;
    settle();
    chk("r_late_vld", {30'b0, bus.o_if_valid, bus.o_dm_valid}, 32'd0);
    chk("r_if_rdata", bus.o_if_rdata, 32'd0);
    chk("r_new_rdy", 32'(bus.o_if_ready), 32'd1);
    step();
    bus.i_mem_valid = 1'b0;
    bus.i_if_req    = 1'b0;
    mem_cycle(0, 0, 1'b0, 32'h0000_0040, 1'b0, 32'd0, 4'hf,
              32'h1111_2222);

    // spurious response while idle
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'h5555_AAAA;
    settle();
    chk_quiet("spur");
    chk("spur_rdata", bus.o_if_rdata | bus.o_dm_rdata, 32'd0);
    step();
    bus.i_mem_valid = 1'b0;
    settle();
    chk("spur_req", 32'(bus.o_mem_req), 32'd0);
    bus.i_dm_req   = 1'b1;
    bus.i_dm_addr  = 32'h0000_0010;
    bus.i_dm_wen   = 1'b1;
    bus.i_dm_wdata = 32'h0000_00FF;
    bus.i_dm_mask  = 4'b0001;
    settle();
    chk("spur_idle", 32'(bus.o_dm_ready), 32'd1);
    step();
    bus.i_dm_req = 1'b0;
    mem_cycle(1, 1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_00FF,
              4'b0001, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
